// File: rtl/z80_bus_sequencer_if.sv
// Bus bundle between the execution core / external bus and the Z80 bus sequencer.
// Latency: none (signal grouping only).
// Backpressure: none; the core must hold start until the cycle is accepted (busy low or done pulse).
//
// Ports:
//   request side : start, cycle_type, io_write, addr, wdata, i_reg
//   external bus : data_in, wait_n (in); a, d_out, d_oe, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n (out)
//   status       : busy, done, rdata, r_reg
interface z80_bus_sequencer_if;
    logic        start;
    logic [1:0]  cycle_type;
    logic        io_write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  i_reg;
    logic [7:0]  data_in;
    logic        wait_n;

    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic [6:0]  r_reg;

    // master: the sequencer itself
    modport master (
        input  start, cycle_type, io_write, addr, wdata, i_reg, data_in, wait_n,
        output a, d_out, d_oe, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        output busy, done, rdata, r_reg
    );

    // slave: the core plus external memory/I/O that talk to the sequencer
    modport slave (
        output start, cycle_type, io_write, addr, wdata, i_reg, data_in, wait_n,
        input  a, d_out, d_oe, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        input  busy, done, rdata, r_reg
    );
endinterface

// File: rtl/z80_bus_sequencer.sv
// Z80 external bus cycle generator: M1 fetch + refresh, memory read/write, I/O read/write.
// Latency: T1p0 one clk after accept; 8/6/6/8 clk for M1/mem rd/mem wr/IO, +2 clk per wait state.
// Backpressure: a new request is accepted only when idle or in the done slot; wait_n stretches cycles.
//
// Ports: clk (2x T-state rate), reset_n (async, active-low), bus (z80_bus_sequencer_if.master).
// Every bus output is a flop: the combinational block computes the value for the *next* slot.
module z80_bus_sequencer (
    input  logic                 clk,
    input  logic                 reset_n,
    z80_bus_sequencer_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    localparam logic [1:0] CT_M1  = 2'd0;
    localparam logic [1:0] CT_MRD = 2'd1;
    localparam logic [1:0] CT_MWR = 2'd2;
    localparam logic [1:0] CT_IO  = 2'd3;

    state_t      state, state_nxt;
    logic        phase, phase_nxt;

    // request fields latched at accept
    logic [1:0]  cyc_type;
    logic        cyc_iow;
    logic [7:0]  cyc_wdata;
    logic [7:0]  cyc_i;

    // registered outputs and their next-slot values
    logic [15:0] a_q,      a_nxt;
    logic [7:0]  d_out_q,  d_out_nxt;
    logic        d_oe_q,   d_oe_nxt;
    logic        m1_q,     m1_nxt;
    logic        mreq_q,   mreq_nxt;
    logic        iorq_q,   iorq_nxt;
    logic        rd_q,     rd_nxt;
    logic        wr_q,     wr_nxt;
    logic        rfsh_q,   rfsh_nxt;
    logic        busy_q,   busy_nxt;
    logic        done_q,   done_nxt;
    logic [7:0]  rdata_q,  rdata_nxt;
    logic [6:0]  r_q,      r_nxt;

    logic        accept;
    logic [1:0]  nxt_type;
    logic        nxt_iow;
    logic        cur_is_read;
    logic        cur_is_write;
    logic        nxt_is_write;
    logic        last_sample;
    logic        early_slot;
    logic        t3p0_slot;
    logic        io_slot;
    logic        wr_slot;
    logic        data_slot;

    always_comb begin
        accept       = bus.start && (!busy_q || done_q);
        nxt_type     = accept ? bus.cycle_type : cyc_type;
        nxt_iow      = accept ? bus.io_write   : cyc_iow;
        cur_is_write = (cyc_type == CT_MWR) || ((cyc_type == CT_IO) && cyc_iow);
        cur_is_read  = !cur_is_write;
        nxt_is_write = (nxt_type == CT_MWR) || ((nxt_type == CT_IO) && nxt_iow);

        // I/O skips the T2p1 sample: its first sample is in the automatic TW.
        last_sample  = phase && bus.wait_n &&
                       (((state == S_T2) && (cyc_type != CT_IO)) || (state == S_TW));

        state_nxt = state;
        phase_nxt = ~phase;
        case (state)
            S_IDLE: begin
                phase_nxt = 1'b0;
                if (accept) state_nxt = S_T1;
            end
            S_T1: if (phase) state_nxt = S_T2;
            S_T2: if (phase) state_nxt = ((cyc_type == CT_IO) || !bus.wait_n) ? S_TW : S_T3;
            S_TW: if (phase && bus.wait_n) state_nxt = S_T3;
            S_T3: if (phase) state_nxt = (cyc_type == CT_M1) ? S_T4 : (accept ? S_T1 : S_IDLE);
            S_T4: if (phase) state_nxt = accept ? S_T1 : S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = 1'b0;
            end
        endcase
        if (state_nxt == S_IDLE) phase_nxt = 1'b0;

        // slot classes of the next slot; TW reuses the T2p1 strobe pattern
        early_slot = ((state_nxt == S_T1) && phase_nxt) || (state_nxt == S_T2) || (state_nxt == S_TW);
        t3p0_slot  = (state_nxt == S_T3) && !phase_nxt;
        io_slot    = (state_nxt == S_T2) || (state_nxt == S_TW) || t3p0_slot;
        wr_slot    = ((state_nxt == S_T2) && phase_nxt) || (state_nxt == S_TW) || t3p0_slot;
        data_slot  = ((state_nxt == S_T1) && phase_nxt) || (state_nxt == S_T2) ||
                     (state_nxt == S_TW) || (state_nxt == S_T3);

        m1_nxt   = 1'b1;
        mreq_nxt = 1'b1;
        iorq_nxt = 1'b1;
        rd_nxt   = 1'b1;
        wr_nxt   = 1'b1;
        rfsh_nxt = 1'b1;
        d_oe_nxt = 1'b0;
        case (nxt_type)
            CT_M1: begin
                m1_nxt   = !((state_nxt == S_T1) || (state_nxt == S_T2) || (state_nxt == S_TW));
                mreq_nxt = !(early_slot || ((state_nxt == S_T3) && phase_nxt) ||
                             ((state_nxt == S_T4) && !phase_nxt));
                rd_nxt   = !early_slot;
                rfsh_nxt = !((state_nxt == S_T3) || (state_nxt == S_T4));
            end
            CT_MRD: begin
                mreq_nxt = !(early_slot || t3p0_slot);
                rd_nxt   = !(early_slot || t3p0_slot);
            end
            CT_MWR: begin
                mreq_nxt = !(early_slot || t3p0_slot);
                wr_nxt   = !wr_slot;
                d_oe_nxt = data_slot;
            end
            default: begin
                iorq_nxt = !io_slot;
                if (nxt_iow) begin
                    wr_nxt   = !io_slot;
                    d_oe_nxt = data_slot;
                end else begin
                    rd_nxt   = !io_slot;
                end
            end
        endcase

        // a only moves at T1p0 and at the M1 refresh slot; otherwise it holds
        a_nxt = a_q;
        if (accept)
            a_nxt = bus.addr;
        else if (t3p0_slot && (cyc_type == CT_M1))
            a_nxt = {cyc_i, 1'b0, r_q};

        d_out_nxt = d_out_q;
        if ((state_nxt == S_T1) && phase_nxt && nxt_is_write)
            d_out_nxt = cyc_wdata;

        rdata_nxt = (last_sample && cur_is_read) ? bus.data_in : rdata_q;

        // refresh counter steps as the M1 done slot ends, wrapping at 128
        r_nxt = ((state == S_T4) && phase) ? r_q + 7'd1 : r_q;

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = ((state_nxt == S_T3) && phase_nxt && (nxt_type != CT_M1)) ||
                   ((state_nxt == S_T4) && phase_nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            cyc_type  <= CT_M1;
            cyc_iow   <= 1'b0;
            cyc_wdata <= 8'h00;
            cyc_i     <= 8'h00;
            a_q       <= 16'h0000;
            d_out_q   <= 8'h00;
            d_oe_q    <= 1'b0;
            m1_q      <= 1'b1;
            mreq_q    <= 1'b1;
            iorq_q    <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            rfsh_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
            r_q       <= 7'h00;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            if (accept) begin
                cyc_type  <= bus.cycle_type;
                cyc_iow   <= bus.io_write;
                cyc_wdata <= bus.wdata;
                cyc_i     <= bus.i_reg;
            end
            a_q       <= a_nxt;
            d_out_q   <= d_out_nxt;
            d_oe_q    <= d_oe_nxt;
            m1_q      <= m1_nxt;
            mreq_q    <= mreq_nxt;
            iorq_q    <= iorq_nxt;
            rd_q      <= rd_nxt;
            wr_q      <= wr_nxt;
            rfsh_q    <= rfsh_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            rdata_q   <= rdata_nxt;
            r_q       <= r_nxt;
        end
    end

    assign bus.a      = a_q;
    assign bus.d_out  = d_out_q;
    assign bus.d_oe   = d_oe_q;
    assign bus.m1_n   = m1_q;
    assign bus.mreq_n = mreq_q;
    assign bus.iorq_n = iorq_q;
    assign bus.rd_n   = rd_q;
    assign bus.wr_n   = wr_q;
    assign bus.rfsh_n = rfsh_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.r_reg  = r_q;
endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Scoreboard bench for z80_bus_sequencer: directed cycles push expected cycle profiles,
// a negedge monitor measures each cycle between busy rise and the done pulse and compares.
// Strobe index order: 5=m1_n 4=mreq_n 3=iorq_n 2=rd_n 1=wr_n 0=rfsh_n.
module tb_z80_bus_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z80_bus_sequencer_if bif ();
    z80_bus_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bif));

    typedef struct {
        int              len;
        logic [5:0][7:0] lo;
        logic [5:0][7:0] first;
        int              oe;
        logic [15:0]     a1;
        logic [15:0]     alast;
        logic [7:0]      rdata;
        logic [6:0]      rreg;
        bit              dchk;
        logic [7:0]      dout;
        int              gap;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;

    int n_chk = 0;
    int n_pass = 0;

    // monitor accumulators
    int          cnt, oe_a, gap_a, stray_a, cycles;
    int          lo_a[6];
    int          first_a[6];
    logic [15:0] a1_a;
    logic [7:0]  d0_a;
    int          dst_a;
    bit          finish_req = 1'b0;

    // stimulus-side reference state
    logic [6:0]  r_model;
    logic [7:0]  last_rd;

    function automatic string sname(input int i);
        case (i)
            5: return "m1_n";
            4: return "mreq_n";
            3: return "iorq_n";
            2: return "rd_n";
            1: return "wr_n";
            default: return "rfsh_n";
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    task automatic clr_acc();
        cnt = 0;
        oe_a = 0;
        dst_a = 1;
        a1_a = 16'h0000;
        d0_a = 8'h00;
        for (int i = 0; i < 6; i++) begin
            lo_a[i] = 0;
            first_a[i] = 0;
        end
    endtask

    initial begin
        clr_acc();
        gap_a = 0;
        stray_a = 0;
        cycles = 0;
    end

    always @(negedge clk) begin
        logic [5:0] s;
        s = {bif.m1_n, bif.mreq_n, bif.iorq_n, bif.rd_n, bif.wr_n, bif.rfsh_n};
        cycles++;
        if (cycles > 20000) begin
            $display("FAIL watchdog: got %0d clocks, limit 20000", cycles);
            n_chk++;
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end else if (!reset_n) begin
            for (int i = 0; i < 6; i++) chk({"reset_", sname(i)}, int'(s[i]), 1);
            chk("reset_d_oe", int'(bif.d_oe), 0);
            chk("reset_busy", int'(bif.busy), 0);
            chk("reset_done", int'(bif.done), 0);
            chk("reset_a", int'(bif.a), 0);
            chk("reset_d_out", int'(bif.d_out), 0);
            chk("reset_rdata", int'(bif.rdata), 0);
            chk("reset_r_reg", int'(bif.r_reg), 0);
            clr_acc();
            gap_a = 0;
            stray_a = 0;
        end else if (finish_req) begin
            chk("idle_strobe_activity_end", stray_a, 0);
            chk("scoreboard_empty_at_end", exp_q.size(), 0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end else if (bif.busy) begin
            cnt++;
            if (cnt == 1) a1_a = bif.a;
            for (int i = 0; i < 6; i++) begin
                if (!s[i]) begin
                    lo_a[i]++;
                    if (first_a[i] == 0) first_a[i] = cnt;
                end
            end
            if (bif.d_oe) begin
                oe_a++;
                if (oe_a == 1) d0_a = bif.d_out;
                else if (bif.d_out != d0_a) dst_a = 0;
            end
            if (bif.done) begin
                chk("scoreboard_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("cycle_len", cnt, mon_e.len);
                    for (int i = 0; i < 6; i++) begin
                        chk({sname(i), "_low_clks"}, lo_a[i], int'(mon_e.lo[i]));
                        chk({sname(i), "_first_low"}, first_a[i], int'(mon_e.first[i]));
                    end
                    chk("d_oe_clks", oe_a, mon_e.oe);
                    chk("a_at_t1p0", int'(a1_a), int'(mon_e.a1));
                    chk("a_at_done", int'(bif.a), int'(mon_e.alast));
                    chk("rdata", int'(bif.rdata), int'(mon_e.rdata));
                    chk("r_reg", int'(bif.r_reg), int'(mon_e.rreg));
                    chk("idle_strobe_activity", stray_a, 0);
                    if (mon_e.dchk) begin
                        chk("d_out", int'(d0_a), int'(mon_e.dout));
                        chk("d_out_stable", dst_a, 1);
                    end
                    if (mon_e.gap >= 0) chk("idle_slots_before", gap_a, mon_e.gap);
                end
                clr_acc();
                gap_a = 0;
                stray_a = 0;
            end
        end else begin
            gap_a++;
            if ((s != 6'h3F) || bif.d_oe || bif.done) stray_a++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    // Issues one cycle, pushes its expected profile, returns during the done slot.
    task automatic issue(input int ty, input bit iow, input logic [15:0] ad, input logic [7:0] wd,
                         input logic [7:0] ir, input logic [7:0] din, input int w, input int gap,
                         input bit poke);
        rec_t e;
        int   slot, first_s, last0;
        bit   wr_cyc;
        e.lo = '0;
        e.first = '0;
        e.oe = 0;
        wr_cyc = (ty == 2) || ((ty == 3) && iow);
        case (ty)
            0: begin
                e.len = 8 + 2 * w;
                e.lo[5] = 8'(4 + 2 * w); e.first[5] = 8'd1;
                e.lo[4] = 8'(5 + 2 * w); e.first[4] = 8'd2;
                e.lo[2] = 8'(3 + 2 * w); e.first[2] = 8'd2;
                e.lo[0] = 8'd4;          e.first[0] = 8'(5 + 2 * w);
            end
            1: begin
                e.len = 6 + 2 * w;
                e.lo[4] = 8'(4 + 2 * w); e.first[4] = 8'd2;
                e.lo[2] = 8'(4 + 2 * w); e.first[2] = 8'd2;
            end
            2: begin
                e.len = 6 + 2 * w;
                e.lo[4] = 8'(4 + 2 * w); e.first[4] = 8'd2;
                e.lo[1] = 8'(2 + 2 * w); e.first[1] = 8'd4;
            end
            default: begin
                e.len = 8 + 2 * w;
                e.lo[3] = 8'(5 + 2 * w); e.first[3] = 8'd3;
                if (iow) begin e.lo[1] = 8'(5 + 2 * w); e.first[1] = 8'd3; end
                else     begin e.lo[2] = 8'(5 + 2 * w); e.first[2] = 8'd3; end
            end
        endcase
        if (wr_cyc) e.oe = e.len - 1;
        else last_rd = din;
        e.a1 = ad;
        e.alast = (ty == 0) ? {ir, 1'b0, r_model} : ad;
        e.rdata = last_rd;
        e.rreg = r_model;
        e.dchk = wr_cyc;
        e.dout = wd;
        e.gap = gap;
        exp_q.push_back(e);
        if (ty == 0) r_model = r_model + 7'd1;

        bif.start = 1'b1;
        bif.cycle_type = 2'(ty);
        bif.io_write = iow;
        bif.addr = ad;
        bif.wdata = wd;
        bif.i_reg = ir;
        bif.data_in = din;
        bif.wait_n = (w > 0) ? 1'b0 : 1'b1;
        tick();
        bif.start = 1'b0;
        slot = 1;
        first_s = (ty == 3) ? 6 : 4;
        last0 = first_s + 2 * (w - 1);
        while (slot < e.len) begin
            if (poke && (slot == 3)) begin
                bif.start = 1'b1;
                bif.addr = 16'hFFFF;
                bif.cycle_type = 2'd2;
            end else begin
                bif.start = 1'b0;
            end
            tick();
            slot++;
            if ((w > 0) && (slot == last0 + 1)) bif.wait_n = 1'b1;
        end
        bif.start = 1'b0;
    endtask

    initial begin
        r_model = 7'd0;
        last_rd = 8'h00;
        bif.start = 1'b0;
        bif.cycle_type = 2'd0;
        bif.io_write = 1'b0;
        bif.addr = 16'h0000;
        bif.wdata = 8'h00;
        bif.i_reg = 8'h00;
        bif.data_in = 8'h00;
        bif.wait_n = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        issue(0, 1'b0, 16'h0100, 8'h00, 8'h3F, 8'hC3, 0, -1, 1'b0);  // M1 fetch
        idle(2);
        issue(2, 1'b0, 16'h8000, 8'h5A, 8'h00, 8'hEE, 2, 2, 1'b0);   // mem write, 2 waits
        idle(3);
        issue(3, 1'b0, 16'h00FE, 8'h00, 8'h00, 8'h7F, 0, 3, 1'b0);   // I/O read
        idle(1);
        issue(1, 1'b0, 16'h4321, 8'h00, 8'h00, 8'hA5, 1, 1, 1'b1);   // mem read, stray start mid-cycle
        idle(2);
        issue(3, 1'b1, 16'h1010, 8'h99, 8'h00, 8'h11, 1, 2, 1'b0);   // I/O write, 1 wait
        idle(1);
        issue(0, 1'b0, 16'h0777, 8'h00, 8'h40, 8'h3E, 1, 1, 1'b0);   // M1 with 1 wait
        idle(2);
        for (int i = 0; i < 128; i++)
            issue(0, 1'b0, 16'(16'h2000 + i), 8'h00, 8'h3F, 8'(i * 7 + 1), 0, (i == 0) ? 2 : 0, 1'b0);
        issue(1, 1'b0, 16'hBEEF, 8'h00, 8'h00, 8'h3C, 0, 0, 1'b0);   // mem read straight after M1

        // abort an M1 at T3p0 with a reset pulse that ends before the next clock edge
        idle(2);
        bif.start = 1'b1;
        bif.cycle_type = 2'd0;
        bif.addr = 16'h2222;
        bif.i_reg = 8'h55;
        tick();
        bif.start = 1'b0;
        idle(4);
        reset_n = 1'b0;
        r_model = 7'd0;
        last_rd = 8'h00;
        #5 reset_n = 1'b1;
        idle(2);
        issue(1, 1'b0, 16'h1234, 8'h00, 8'h00, 8'h6E, 0, -1, 1'b0);
        idle(2);
        issue(0, 1'b0, 16'h0200, 8'h00, 8'h12, 8'h00, 0, 2, 1'b0);
        idle(3);
        finish_req = 1'b1;
    end
endmodule
